// File: rtl/ysyx_22040632_axi_pkg.sv
// Shared types for the requester-to-AXI4 arbiter: FSM states, AXI constants,
// and the latched request record.
package ysyx_22040632_axi_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AR   = 3'd1,
        R    = 3'd2,
        AW   = 3'd3,
        W    = 3'd4,
        B    = 3'd5
    } state_t;

    localparam logic [1:0] BURST_INCR = 2'b01;
    localparam logic [1:0] RESP_OKAY  = 2'b00;

    // Width-independent request fields; the address is latched alongside.
    typedef struct packed {
        logic       wr;
        logic [2:0] size;
        logic [7:0] len;
    } rw_req_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_22040632_rr_arb.sv
// Channel arbiter: request vector in, one-hot grant out, advance strobe.
// YSYX_22040632_ARB_RR_EN selects round-robin; otherwise lowest index wins.
module ysyx_22040632_rr_arb
    import ysyx_22040632_axi_pkg::*;
#(
    parameter int NUM_CH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    input  logic              adv,
    output logic [NUM_CH-1:0] gnt
);

`ifdef YSYX_22040632_ARB_RR_EN
    localparam int IDX_W = idx_w(NUM_CH);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    int               best;
    int               dist;

    // Pick the requester with the smallest distance from ptr, modulo NUM_CH.
    always_comb begin
        gnt  = '0;
        win  = ptr;
        best = NUM_CH;
        dist = 0;
        for (int j = 0; j < NUM_CH; j++) begin
            dist = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + NUM_CH - int'(ptr));
            if (req[j] && dist < best) begin
                best   = dist;
                gnt    = '0;
                gnt[j] = 1'b1;
                win    = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ptr <= '0;
        else if (adv && |req)
            ptr <= (win == IDX_W'(NUM_CH - 1)) ? '0 : win + IDX_W'(1);
    end
`else
    assign gnt = req & (~req + NUM_CH'(1));

    logic unused_arb;
    assign unused_arb = ^{clk, rst, adv};
`endif

endmodule

// File: rtl/ysyx_22040632_rw2axi_arb.sv
// Multiplexes NUM_CH IF/MEM-style requesters onto one AXI4 master port,
// one outstanding transaction at a time. YSYX_22040632_ARB_RR_EN: round-robin.
module ysyx_22040632_rw2axi_arb
    import ysyx_22040632_axi_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int ID_WIDTH   = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,

    input  logic [NUM_CH-1:0]                     rw_valid,
    input  logic [NUM_CH-1:0]                     rw_req,
    input  logic [NUM_CH-1:0][ADDR_WIDTH-1:0]     rw_addr,
    input  logic [NUM_CH-1:0][2:0]                rw_size,
    input  logic [NUM_CH-1:0][7:0]                rw_len,
    input  logic [NUM_CH-1:0][DATA_WIDTH-1:0]     rw_w_data,
    input  logic [NUM_CH-1:0][DATA_WIDTH/8-1:0]   w_strb,
    output logic [NUM_CH-1:0]                     rw_ready,
    output logic [DATA_WIDTH-1:0]                 data_read,
    output logic [NUM_CH-1:0]                     r_hs,
    output logic [NUM_CH-1:0]                     r_last,
    output logic [NUM_CH-1:0]                     w_hs,
    output logic [NUM_CH-1:0]                     rw_err,

    output logic                                  axi_aw_valid,
    input  logic                                  axi_aw_ready,
    output logic [ID_WIDTH-1:0]                   axi_aw_id,
    output logic [ADDR_WIDTH-1:0]                 axi_aw_addr,
    output logic [7:0]                            axi_aw_len,
    output logic [2:0]                            axi_aw_size,
    output logic [1:0]                            axi_aw_burst,
    output logic                                  axi_aw_lock,
    output logic [3:0]                            axi_aw_cache,
    output logic [2:0]                            axi_aw_prot,
    output logic [3:0]                            axi_aw_qos,

    output logic                                  axi_w_valid,
    input  logic                                  axi_w_ready,
    output logic [DATA_WIDTH-1:0]                 axi_w_data,
    output logic [DATA_WIDTH/8-1:0]               axi_w_strb,
    output logic                                  axi_w_last,

    input  logic                                  axi_b_valid,
    output logic                                  axi_b_ready,
    input  logic [ID_WIDTH-1:0]                   axi_b_id,
    input  logic [1:0]                            axi_b_resp,

    output logic                                  axi_ar_valid,
    input  logic                                  axi_ar_ready,
    output logic [ID_WIDTH-1:0]                   axi_ar_id,
    output logic [ADDR_WIDTH-1:0]                 axi_ar_addr,
    output logic [7:0]                            axi_ar_len,
    output logic [2:0]                            axi_ar_size,
    output logic [1:0]                            axi_ar_burst,
    output logic                                  axi_ar_lock,
    output logic [3:0]                            axi_ar_cache,
    output logic [2:0]                            axi_ar_prot,
    output logic [3:0]                            axi_ar_qos,

    input  logic                                  axi_r_valid,
    output logic                                  axi_r_ready,
    input  logic [ID_WIDTH-1:0]                   axi_r_id,
    input  logic [DATA_WIDTH-1:0]                 axi_r_data,
    input  logic [1:0]                            axi_r_resp,
    input  logic                                  axi_r_last
);

    localparam int IDX_W = idx_w(NUM_CH);

    state_t                  state, nxt;
    logic [NUM_CH-1:0]       gnt;
    logic [IDX_W-1:0]        gi;
    logic [IDX_W-1:0]        gidx;
    rw_req_t                 ctl;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              cnt;
    logic                    err_q;
    logic                    ar_valid_q;
    logic                    aw_valid_q;
    logic                    arb_adv;

    assign arb_adv = (state == IDLE) && |rw_valid;

    ysyx_22040632_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (rw_valid),
        .adv (arb_adv),
        .gnt (gnt)
    );

    always_comb begin
        gi = '0;
        for (int j = 0; j < NUM_CH; j++)
            if (gnt[j]) gi = IDX_W'(j);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= nxt;
    end

    always_comb begin
        nxt         = state;
        rw_ready    = '0;
        r_hs        = '0;
        r_last      = '0;
        w_hs        = '0;
        rw_err      = '0;
        data_read   = '0;
        axi_r_ready = 1'b0;
        axi_w_valid = 1'b0;
        axi_w_data  = '0;
        axi_w_strb  = '0;
        axi_w_last  = 1'b0;
        axi_b_ready = 1'b0;
        unique case (state)
            IDLE: if (|rw_valid) nxt = rw_req[gi] ? AW : AR;
            AR:   if (axi_ar_valid && axi_ar_ready) nxt = R;
            AW:   if (axi_aw_valid && axi_aw_ready) nxt = W;
            R: begin
                axi_r_ready = 1'b1;
                if (axi_r_valid) begin
                    r_hs[gidx] = 1'b1;
                    data_read  = axi_r_data;
                    if (axi_r_last) begin
                        r_last[gidx]   = 1'b1;
                        rw_ready[gidx] = 1'b1;
                        rw_err[gidx]   = err_q | (axi_r_resp != RESP_OKAY);
                        nxt            = IDLE;
                    end
                end
            end
            W: begin
                // Data comes straight from the requester, which steps on w_hs.
                axi_w_valid = 1'b1;
                axi_w_data  = rw_w_data[gidx];
                axi_w_strb  = w_strb[gidx];
                axi_w_last  = (cnt == ctl.len);
                if (axi_w_ready) begin
                    w_hs[gidx] = 1'b1;
                    if (axi_w_last) nxt = B;
                end
            end
            B: begin
                axi_b_ready = 1'b1;
                if (axi_b_valid) begin
                    rw_ready[gidx] = 1'b1;
                    rw_err[gidx]   = err_q | (axi_b_resp != RESP_OKAY);
                    nxt            = IDLE;
                end
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gidx       <= '0;
            ctl        <= '0;
            addr_q     <= '0;
            cnt        <= '0;
            err_q      <= 1'b0;
            ar_valid_q <= 1'b0;
            aw_valid_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: if (|rw_valid) begin
                    gidx       <= gi;
                    ctl        <= '{wr: rw_req[gi], size: rw_size[gi], len: rw_len[gi]};
                    addr_q     <= rw_addr[gi];
                    cnt        <= '0;
                    err_q      <= 1'b0;
                    ar_valid_q <= ~rw_req[gi];
                    aw_valid_q <= rw_req[gi];
                end
                AR: if (axi_ar_ready) ar_valid_q <= 1'b0;
                AW: if (axi_aw_ready) aw_valid_q <= 1'b0;
                // Any bad beat marks the whole burst as failed.
                R:  if (axi_r_valid && axi_r_resp != RESP_OKAY) err_q <= 1'b1;
                W:  if (axi_w_ready) cnt <= axi_w_last ? 8'd0 : cnt + 8'd1;
                default: ;
            endcase
        end
    end

    assign axi_ar_valid = ar_valid_q;
    assign axi_ar_id    = ID_WIDTH'(gidx);
    assign axi_ar_addr  = addr_q;
    assign axi_ar_len   = ctl.len;
    assign axi_ar_size  = ctl.size;
    assign axi_ar_burst = ar_valid_q ? BURST_INCR : 2'b00;
    assign axi_ar_lock  = 1'b0;
    assign axi_ar_cache = 4'd0;
    assign axi_ar_prot  = 3'd0;
    assign axi_ar_qos   = 4'd0;

    assign axi_aw_valid = aw_valid_q;
    assign axi_aw_id    = ID_WIDTH'(gidx);
    assign axi_aw_addr  = addr_q;
    assign axi_aw_len   = ctl.len;
    assign axi_aw_size  = ctl.size;
    assign axi_aw_burst = aw_valid_q ? BURST_INCR : 2'b00;
    assign axi_aw_lock  = 1'b0;
    assign axi_aw_cache = 4'd0;
    assign axi_aw_prot  = 3'd0;
    assign axi_aw_qos   = 4'd0;

    logic unused_top;
    assign unused_top = ^{axi_r_id, axi_b_id, ctl.wr};

endmodule

// File: tb/tb_ysyx_22040632_rw2axi_arb.sv
// Directed bench for ysyx_22040632_rw2axi_arb: a table of single transactions
// against a small AXI slave model, plus arbitration and mid-burst reset sequences.
module tb_ysyx_22040632_rw2axi_arb;
    import ysyx_22040632_axi_pkg::*;

    localparam int NC = 2;
    localparam int DW = 64;
    localparam int AW = 32;
    localparam int IW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [NC-1:0]             rw_valid = '0, rw_req = '0;
    logic [NC-1:0][AW-1:0]     rw_addr = '0;
    logic [NC-1:0][2:0]        rw_size = '0;
    logic [NC-1:0][7:0]        rw_len = '0;
    logic [NC-1:0][DW-1:0]     rw_w_data = '0;
    logic [NC-1:0][DW/8-1:0]   w_strb = '0;
    logic [NC-1:0]             rw_ready, r_hs, r_last, w_hs, rw_err;
    logic [DW-1:0]             data_read;

    logic axi_aw_valid, axi_aw_lock, axi_w_valid, axi_w_last, axi_b_ready;
    logic axi_ar_valid, axi_ar_lock, axi_r_ready;
    logic [IW-1:0] axi_aw_id, axi_ar_id;
    logic [AW-1:0] axi_aw_addr, axi_ar_addr;
    logic [7:0] axi_aw_len, axi_ar_len;
    logic [2:0] axi_aw_size, axi_ar_size, axi_aw_prot, axi_ar_prot;
    logic [1:0] axi_aw_burst, axi_ar_burst;
    logic [3:0] axi_aw_cache, axi_ar_cache, axi_aw_qos, axi_ar_qos;
    logic [DW-1:0] axi_w_data;
    logic [DW/8-1:0] axi_w_strb;
    logic axi_aw_ready = 0, axi_w_ready = 0, axi_b_valid = 0, axi_ar_ready = 0;
    logic axi_r_valid = 0, axi_r_last = 0;
    logic [IW-1:0] axi_b_id = '0, axi_r_id = '0;
    logic [1:0] axi_b_resp = '0, axi_r_resp = '0;
    logic [DW-1:0] axi_r_data = '0;

    ysyx_22040632_rw2axi_arb #(.NUM_CH(NC), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .rw_valid(rw_valid), .rw_req(rw_req), .rw_addr(rw_addr), .rw_size(rw_size),
        .rw_len(rw_len), .rw_w_data(rw_w_data), .w_strb(w_strb),
        .rw_ready(rw_ready), .data_read(data_read), .r_hs(r_hs), .r_last(r_last),
        .w_hs(w_hs), .rw_err(rw_err),
        .axi_aw_valid(axi_aw_valid), .axi_aw_ready(axi_aw_ready), .axi_aw_id(axi_aw_id),
        .axi_aw_addr(axi_aw_addr), .axi_aw_len(axi_aw_len), .axi_aw_size(axi_aw_size),
        .axi_aw_burst(axi_aw_burst), .axi_aw_lock(axi_aw_lock), .axi_aw_cache(axi_aw_cache),
        .axi_aw_prot(axi_aw_prot), .axi_aw_qos(axi_aw_qos),
        .axi_w_valid(axi_w_valid), .axi_w_ready(axi_w_ready), .axi_w_data(axi_w_data),
        .axi_w_strb(axi_w_strb), .axi_w_last(axi_w_last),
        .axi_b_valid(axi_b_valid), .axi_b_ready(axi_b_ready), .axi_b_id(axi_b_id),
        .axi_b_resp(axi_b_resp),
        .axi_ar_valid(axi_ar_valid), .axi_ar_ready(axi_ar_ready), .axi_ar_id(axi_ar_id),
        .axi_ar_addr(axi_ar_addr), .axi_ar_len(axi_ar_len), .axi_ar_size(axi_ar_size),
        .axi_ar_burst(axi_ar_burst), .axi_ar_lock(axi_ar_lock), .axi_ar_cache(axi_ar_cache),
        .axi_ar_prot(axi_ar_prot), .axi_ar_qos(axi_ar_qos),
        .axi_r_valid(axi_r_valid), .axi_r_ready(axi_r_ready), .axi_r_id(axi_r_id),
        .axi_r_data(axi_r_data), .axi_r_resp(axi_r_resp), .axi_r_last(axi_r_last)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [NC-1:0] oh(input bit b, input int ch);
        return b ? (NC'(1) << ch) : '0;
    endfunction

    function automatic logic [DW-1:0] rpat(input int b);
        return {32'hDA7A_0000 + 32'(b), 32'h1234_5678 ^ 32'(b)};
    endfunction

    function automatic logic [DW-1:0] wpat(input int b);
        return {32'hC0DE_0000 + 32'(b), 32'h8765_4321 ^ 32'(b)};
    endfunction

    typedef struct {
        int         ch;
        bit         wr;
        logic [31:0] addr;
        int         len;
        logic [2:0] size;
        logic [7:0] strb;
        bit         tgl;      // slave readies toggle every other cycle
        int         bad;      // read: beat with SLVERR; write: >=0 gives SLVERR on b
        bit         exp_err;
        int         exp_lat;  // edges from rw_valid to completion, 0 = not checked
    } vec_t;

    vec_t vecs[6];

    task automatic do_reset();
        rst = 1'b1;
        rw_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        int beat = 0, naddr = 0, lat = 0;
        bit done = 0, rdy, hs, fin;
        @(negedge clk);
        rw_valid[v.ch]  = 1'b1;
        rw_req[v.ch]    = v.wr;
        rw_addr[v.ch]   = v.addr;
        rw_size[v.ch]   = v.size;
        rw_len[v.ch]    = 8'(v.len);
        w_strb[v.ch]    = v.strb;
        rw_w_data[v.ch] = wpat(0);
        for (int c = 1; c <= 2000 && !done; c++) begin
            @(negedge clk);
            rw_w_data[v.ch] = wpat(beat);
            rdy = v.tgl ? ((c % 2) == 1) : 1'b1;
            axi_ar_ready = rdy;
            axi_aw_ready = rdy;
            axi_w_ready  = rdy;
            axi_r_valid  = axi_r_ready && rdy;
            axi_r_data   = rpat(beat);
            axi_r_last   = (beat == v.len);
            axi_r_resp   = (!v.wr && beat == v.bad) ? 2'b10 : 2'b00;
            axi_b_valid  = axi_b_ready && rdy;
            axi_b_resp   = (v.wr && v.bad >= 0) ? 2'b10 : 2'b00;
            #1;
            if ((axi_ar_valid && axi_ar_ready) || (axi_aw_valid && axi_aw_ready)) begin
                naddr++;
                check("addr id",   64'(v.wr ? axi_aw_id : axi_ar_id), 64'(v.ch));
                check("addr",      64'(v.wr ? axi_aw_addr : axi_ar_addr), 64'(v.addr));
                check("addr len",  64'(v.wr ? axi_aw_len : axi_ar_len), 64'(v.len));
                check("addr size", 64'(v.wr ? axi_aw_size : axi_ar_size), 64'(v.size));
                check("addr burst",64'(v.wr ? axi_aw_burst : axi_ar_burst), 64'(2'b01));
                check("addr dir",  64'({axi_ar_valid, axi_aw_valid}), v.wr ? 64'd1 : 64'd2);
            end
            if (v.wr) begin
                hs  = axi_w_valid && axi_w_ready;
                fin = axi_b_valid && axi_b_ready;
                check("w_hs", 64'(w_hs), 64'(oh(hs, v.ch)));
                if (axi_w_valid) begin
                    check("w_last", 64'(axi_w_last), 64'(beat == v.len));
                    check("w_data", 64'(axi_w_data), 64'(wpat(beat)));
                    check("w_strb", 64'(axi_w_strb), 64'(v.strb));
                end
            end else begin
                hs  = axi_r_valid && axi_r_ready;
                fin = hs && (beat == v.len);
                check("r_hs", 64'(r_hs), 64'(oh(hs, v.ch)));
                check("r_last", 64'(r_last), 64'(oh(fin, v.ch)));
                if (hs) check("data_read", 64'(data_read), 64'(rpat(beat)));
            end
            check("rw_ready", 64'(rw_ready), 64'(oh(fin, v.ch)));
            if (fin) begin
                check("rw_err", 64'(rw_err), 64'(oh(v.exp_err, v.ch)));
                lat  = c + 1;
                done = 1;
                rw_valid[v.ch] = 1'b0;
            end
            if (hs) beat++;
        end
        check("txn done", 64'(done), 64'd1);
        check("beats", 64'(beat), 64'(v.len + 1));
        check("addr handshakes", 64'(naddr), 64'd1);
        if (v.exp_lat > 0) check("latency", 64'(lat), 64'(v.exp_lat));
        @(negedge clk);
        {axi_ar_ready, axi_aw_ready, axi_w_ready, axi_r_valid, axi_b_valid} = '0;
    endtask

    initial begin
        int ng;
        int bt;
        bit rst_done;
        logic [IW-1:0] grants[4];
        int exp_g[4];

        vecs[0] = '{0, 1'b0, 32'h8000_0000, 0,   3'd3, 8'hFF, 1'b0, -1, 1'b0, 3};
        vecs[1] = '{1, 1'b1, 32'h8000_1000, 3,   3'd3, 8'hFF, 1'b1, -1, 1'b0, 0};
        vecs[2] = '{0, 1'b0, 32'h8000_2000, 3,   3'd3, 8'hFF, 1'b1,  1, 1'b1, 0};
        vecs[3] = '{1, 1'b0, 32'h8001_0000, 255, 3'd3, 8'hFF, 1'b0, -1, 1'b0, 0};
        vecs[4] = '{0, 1'b1, 32'h8000_3008, 0,   3'd2, 8'h0F, 1'b0,  0, 1'b1, 0};
        vecs[5] = '{1, 1'b0, 32'h8000_4000, 1,   3'd3, 8'hFF, 1'b0, -1, 1'b0, 0};
`ifdef YSYX_22040632_ARB_RR_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset state", 64'(dut.state), 64'(IDLE));
        check("reset cnt", 64'(dut.cnt), 64'd0);
        check("reset valids", 64'({axi_ar_valid, axi_aw_valid, axi_w_valid, axi_r_ready, axi_b_ready}), 64'd0);
        check("reset pulses", 64'({rw_ready, r_hs, r_last, w_hs, rw_err}), 64'd0);
        check("reset data", 64'(data_read), 64'd0);
        check("reset addr", 64'({axi_ar_addr, axi_ar_burst, axi_aw_burst}), 64'd0);
        check("reset sideband", 64'({axi_ar_lock, axi_ar_cache, axi_ar_prot, axi_ar_qos,
                                     axi_aw_lock, axi_aw_cache, axi_aw_prot, axi_aw_qos}), 64'd0);
`ifdef YSYX_22040632_ARB_RR_EN
        check("reset rr ptr", 64'(dut.u_arb.ptr), 64'd0);
`endif
        rst = 1'b0;

        for (int i = 0; i < 6; i++) run_vec(vecs[i]);

        // Both channels request continuously; record grant order from ar_id.
        do_reset();
        rw_req = '0;
        rw_len = '0;
        rw_valid = 2'b11;
        ng = 0;
        for (int c = 0; c < 60 && ng < 4; c++) begin
            @(negedge clk);
            axi_ar_ready = 1'b1;
            axi_r_valid  = axi_r_ready;
            axi_r_last   = 1'b1;
            axi_r_resp   = 2'b00;
            #1;
            if (axi_ar_valid) begin
                grants[ng] = axi_ar_id;
                ng++;
            end
        end
        rw_valid = '0;
        repeat (4) begin
            @(negedge clk);
            axi_r_valid = axi_r_ready;
        end
        check("arb grant count", 64'(ng), 64'd4);
        for (int i = 0; i < 4; i++) check("arb grant", 64'(grants[i]), 64'(exp_g[i]));
        @(negedge clk);
        {axi_ar_ready, axi_r_valid, axi_r_last} = '0;

        // Reset while beat 2 of a 4-beat write is on the bus.
        @(negedge clk);
        rw_valid[1] = 1'b1;
        rw_req[1]   = 1'b1;
        rw_addr[1]  = 32'h8000_5000;
        rw_size[1]  = 3'd3;
        rw_len[1]   = 8'd3;
        w_strb[1]   = 8'hFF;
        bt = 0;
        rst_done = 0;
        for (int c = 0; c < 40 && !rst_done; c++) begin
            @(negedge clk);
            rw_w_data[1] = wpat(bt);
            axi_aw_ready = 1'b1;
            axi_w_ready  = 1'b1;
            axi_b_valid  = 1'b0;
            #1;
            if (axi_w_valid && bt == 1) begin
                rst = 1'b1;
                rw_valid = '0;
                #1;
                check("rst async valids", 64'({axi_ar_valid, axi_aw_valid, axi_w_valid}), 64'd0);
                check("rst async pulses", 64'({rw_ready, w_hs}), 64'd0);
                check("rst async state", 64'(dut.state), 64'(IDLE));
                rst_done = 1;
            end else if (axi_w_valid && axi_w_ready) begin
                bt++;
            end
        end
        check("rst reached beat 2", 64'(rst_done), 64'd1);
        @(negedge clk);
        check("rst next valids", 64'({axi_ar_valid, axi_aw_valid, axi_w_valid, axi_b_ready}), 64'd0);
        check("rst next state", 64'(dut.state), 64'(IDLE));
        check("rst next cnt", 64'(dut.cnt), 64'd0);
        rst = 1'b0;
        axi_b_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("no rw_ready after rst", 64'(rw_ready), 64'd0);
            check("idle after rst", 64'(dut.state), 64'(IDLE));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1);
    end

endmodule
